// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the pipeline's divided-clock generator.
// Owns the half-period ratio and starts and stops the divided clock without
// truncating a high phase. It accepts ratio updates over a valid/ready slot and
// applies them only at a clean boundary. It also emits rise/fall ticks and a
// count of rising edges since the last start.
module clk_div_ctrl #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 5,
    parameter int PCNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,        // active-high async reset despite the name
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              cfg_valid_i,
    input  logic [CNT_W-1:0]  cfg_half_i,
    output logic              cfg_ready_o,
    output logic              cfg_applied_o,
    output logic              clk_out_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [PCNT_W-1:0] period_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HALF_RST = CNT_W'(DEFAULT_HALF);
    localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

    // A zero half-period would never reach its terminal count; treat it as 1.
    function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] h);
        if (h == CNT_ZERO) begin
            return CNT_ONE;
        end else begin
            return h;
        end
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [CNT_W-1:0]    half_r, half_s;
    logic [CNT_W-1:0]    pend_half_r, pend_half_s;
    logic                pend_valid_r, pend_valid_s;
    logic                clk_out_r, clk_s;
    logic                rise_r, rise_s;
    logic                fall_r, fall_s;
    logic                done_r, done_s;
    logic                applied_r, applied_s;
    logic                busy_r;
    logic [PCNT_W-1:0]   pcnt_r, pcnt_s;
    logic                toggle_s;
    logic [CNT_W-1:0]    step_cnt_s;

    // Terminal count of the current phase and the counter value after one step.
    always_comb begin
        toggle_s   = (cnt_r == (half_r - CNT_ONE));
        step_cnt_s = toggle_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    end

    // Next state, counter, divided clock, ticks and period count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        clk_s   = clk_out_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        done_s  = 1'b0;
        pcnt_s  = pcnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                clk_s = 1'b0;
                if (start_i) begin
                    state_s = ST_RUN;
                    pcnt_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_s = step_cnt_s;
                if (toggle_s) begin
                    clk_s  = ~clk_out_r;
                    rise_s = ~clk_out_r;
                    fall_s = clk_out_r;
                    if (!clk_out_r) begin
                        pcnt_s = pcnt_r + PCNT_ONE;
                    end else begin
                        pcnt_s = pcnt_r;
                    end
                end else begin
                    clk_s = clk_out_r;
                end
                if (stop_i) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!clk_out_r) begin
                    // Already low: nothing to finish, leave on this edge.
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    clk_s   = 1'b0;
                    done_s  = 1'b1;
                end else if (toggle_s) begin
                    // High phase completes naturally; fall and done coincide.
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    clk_s   = 1'b0;
                    fall_s  = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                    cnt_s   = step_cnt_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                clk_s   = 1'b0;
            end
        endcase
    end

    // Config slot: capture when free, apply in IDLE or on a falling toggle.
    always_comb begin
        half_s       = half_r;
        pend_half_s  = pend_half_r;
        pend_valid_s = pend_valid_r;
        applied_s    = 1'b0;
        if (pend_valid_r) begin
            if ((state_r == ST_IDLE) || fall_s) begin
                half_s       = pend_half_r;
                pend_valid_s = 1'b0;
                applied_s    = 1'b1;
            end else begin
                pend_valid_s = 1'b1;
            end
        end else if (cfg_valid_i) begin
            pend_half_s  = clamp_half(cfg_half_i);
            pend_valid_s = 1'b1;
        end else begin
            pend_valid_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset drops the divided clock at once.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            cnt_r        <= CNT_ZERO;
            half_r       <= HALF_RST;
            pend_half_r  <= CNT_ZERO;
            pend_valid_r <= 1'b0;
            clk_out_r    <= 1'b0;
            rise_r       <= 1'b0;
            fall_r       <= 1'b0;
            done_r       <= 1'b0;
            applied_r    <= 1'b0;
            busy_r       <= 1'b0;
            pcnt_r       <= '0;
        end else begin
            cnt_r        <= cnt_s;
            half_r       <= half_s;
            pend_half_r  <= pend_half_s;
            pend_valid_r <= pend_valid_s;
            clk_out_r    <= clk_s;
            rise_r       <= rise_s;
            fall_r       <= fall_s;
            done_r       <= done_s;
            applied_r    <= applied_s;
            busy_r       <= (state_s != ST_IDLE);
            pcnt_r       <= pcnt_s;
        end
    end

    assign cfg_ready_o   = ~pend_valid_r;
    assign cfg_applied_o = applied_r;
    assign clk_out_o     = clk_out_r;
    assign rise_o        = rise_r;
    assign fall_o        = fall_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign period_cnt_o  = pcnt_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed vector table, corner-case sequences and
// randomized stimulus against a phase-countdown reference model.
module tb_clk_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic [7:0]  cfg_half_i = 8'd0;
    logic        cfg_ready_o, cfg_applied_o, clk_out_o, rise_o, fall_o, busy_o, done_o;
    logic [15:0] period_cnt_o;

    int errors = 0;
    int checks = 0;

    clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(5), .PCNT_W(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
        .cfg_valid_i(cfg_valid_i), .cfg_half_i(cfg_half_i),
        .cfg_ready_o(cfg_ready_o), .cfg_applied_o(cfg_applied_o),
        .clk_out_o(clk_out_o), .rise_o(rise_o), .fall_o(fall_o),
        .busy_o(busy_o), .done_o(done_o), .period_cnt_o(period_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: 0 idle, 1 running, 2 draining; remaining edges in phase.
    int          m_state;
    bit          m_level;
    int          m_remain;
    int          m_half;
    int          m_pend[$];
    logic [15:0] m_periods;
    bit          m_rise, m_fall, m_done, m_applied;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_level = 0; m_remain = 0; m_half = 5;
        m_pend.delete(); m_periods = 16'd0;
        m_rise = 0; m_fall = 0; m_done = 0; m_applied = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit cv, input int ch);
        bit was_idle;
        bit tog;
        bit started;
        bit fire;
        was_idle = (m_state == 0);
        tog = 0; started = 0;
        fire = cv && (m_pend.size() == 0);
        m_rise = 0; m_fall = 0; m_done = 0; m_applied = 0;
        case (m_state)
            0: if (s) begin m_state = 1; m_periods = 16'd0; started = 1; end
            1: begin
                m_remain--;
                if (m_remain == 0) begin
                    tog = 1;
                    m_level = !m_level;
                    if (m_level) begin m_rise = 1; m_periods++; end
                    else m_fall = 1;
                end
                if (p) m_state = 2;
            end
            default: begin
                if (!m_level) begin m_state = 0; m_done = 1; end
                else begin
                    m_remain--;
                    if (m_remain == 0) begin
                        m_level = 0; m_fall = 1; m_state = 0; m_done = 1;
                    end
                end
            end
        endcase
        if (m_pend.size() > 0 && (was_idle || m_fall)) begin
            m_half = m_pend.pop_front();
            m_applied = 1;
        end else if (fire) begin
            m_pend.push_back((ch == 0) ? 1 : ch);
        end
        if (tog || started) m_remain = m_half;
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic tick(input bit s, input bit p, input bit cv, input logic [7:0] ch);
        start_i = s; stop_i = p; cfg_valid_i = cv; cfg_half_i = ch;
        model_step(s, p, cv, int'(ch));
        @(posedge clk_i);
        #1;
        chk("m_clk_out", clk_out_o, m_level);
        chk("m_rise", rise_o, m_rise);
        chk("m_fall", fall_o, m_fall);
        chk("m_busy", busy_o, (m_state != 0));
        chk("m_done", done_o, m_done);
        chk("m_applied", cfg_applied_o, m_applied);
        chk("m_ready", cfg_ready_o, (m_pend.size() == 0));
        chk("m_period", period_cnt_o, m_periods);
    endtask

    // Assert reset mid-cycle, check the async effect, release on a falling edge.
    task automatic do_reset();
        start_i = 0; stop_i = 0; cfg_valid_i = 0; cfg_half_i = 8'd0;
        #1 rstn_i = 1'b1;
        #1;
        model_reset();
        chk("rst_clk_out", clk_out_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", cfg_ready_o, 1'b1);
        chk("rst_period", period_cnt_o, 16'd0);
        chk("rst_pulses", {rise_o, fall_o, done_o, cfg_applied_o}, 4'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b0;
    endtask

    typedef struct {
        logic        s, p;
        logic        e_clk, e_rise, e_fall, e_busy, e_done;
        logic [15:0] e_pcnt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic s, input logic p, input logic c, input logic r,
                                input logic f, input logic b, input logic d, input logic [15:0] pc);
        vec_t v;
        v.s = s; v.p = p; v.e_clk = c; v.e_rise = r; v.e_fall = f;
        v.e_busy = b; v.e_done = d; v.e_pcnt = pc;
        return v;
    endfunction

    initial begin
        int n;
        // Start at 0, rises at 5 and 15, stop at 17 drains to 20, start at 21, stop low at 23.
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        for (int k = 1; k <= 4; k++)  tbl[k] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        tbl[5] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        for (int k = 6; k <= 9; k++)  tbl[k] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
        for (int k = 11; k <= 14; k++) tbl[k] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
        tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        tbl[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        tbl[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Table: start/run timing, drain from high, stop while low.
        do_reset();
        for (int k = 0; k < 26; k++) begin
            tick(tbl[k].s, tbl[k].p, 1'b0, 8'd0);
            chk("tbl_clk_out", clk_out_o, tbl[k].e_clk);
            chk("tbl_rise", rise_o, tbl[k].e_rise);
            chk("tbl_fall", fall_o, tbl[k].e_fall);
            chk("tbl_busy", busy_o, tbl[k].e_busy);
            chk("tbl_done", done_o, tbl[k].e_done);
            chk("tbl_period", period_cnt_o, tbl[k].e_pcnt);
        end

        // Ratio change offered while high takes effect at the next fall.
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        n = 0;
        while (!clk_out_o && n < 20) begin tick(1'b0, 1'b0, 1'b0, 8'd0); n++; end
        chk("cfg_reach_high", clk_out_o, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 8'd3);
        chk("cfg_ready_low", cfg_ready_o, 1'b0);
        n = 0;
        while (!cfg_applied_o && n < 20) begin tick(1'b0, 1'b0, 1'b0, 8'd0); n++; end
        chk("cfg_applied_wait", n, 32'd4);
        chk("cfg_applied_on_fall", fall_o, 1'b1);
        chk("cfg_ready_back", cfg_ready_o, 1'b1);
        n = 0;
        do begin tick(1'b0, 1'b0, 1'b0, 8'd0); n++; end while (!rise_o && n < 20);
        chk("cfg_low_len", n, 32'd3);
        n = 0;
        do begin tick(1'b0, 1'b0, 1'b0, 8'd0); n++; end while (!fall_o && n < 20);
        chk("cfg_high_len", n, 32'd3);
        tick(1'b0, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 8'd0);

        // Zero half clamps to 1: the output toggles every cycle.
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 8'd0);
        chk("clamp_ready_low", cfg_ready_o, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 8'd0);
        chk("clamp_applied", cfg_applied_o, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        for (int j = 1; j <= 6; j++) begin
            tick(1'b0, 1'b0, 1'b0, 8'd0);
            chk("clamp_clk_out", clk_out_o, j % 2);
            chk("clamp_rise", rise_o, j % 2);
            chk("clamp_fall", fall_o, (j + 1) % 2);
        end

        // Async reset while high, then default timing again.
        tick(1'b0, 1'b1, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b0, 1'b1, 8'd2);
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        n = 0;
        while (!clk_out_o && n < 20) begin tick(1'b0, 1'b0, 1'b0, 8'd0); n++; end
        chk("arst_reach_high", clk_out_o, 1'b1);
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 8'd0);
        for (int j = 1; j <= 15; j++) begin
            tick(1'b0, 1'b0, 1'b0, 8'd0);
            if (j == 4) chk("arst_low_at4", clk_out_o, 1'b0);
            if (j == 5) chk("arst_rise_at5", rise_o, 1'b1);
            if (j == 10) chk("arst_fall_at10", fall_o, 1'b1);
        end
        chk("arst_period15", period_cnt_o, 16'd2);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit s, p, cv;
            logic [7:0] ch;
            s  = ($urandom % 16) == 0;
            p  = ($urandom % 12) == 0;
            cv = ($urandom % 3) == 0;
            ch = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            tick(s, p, cv, ch);
            if ((i % 1000) == 999) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the pipeline's divided-clock generator. It owns the divide ratio and starts and stops the divided clock without truncated pulses. Ratio updates arrive over a valid/ready config handshake and take effect only at a clean period boundary. It also emits single-cycle rise/fall ticks and a period counter for the streaming MNIST stages.

Parameters:
CNT_W, 8, width of the half-period counter and the ratio registers.
DEFAULT_HALF, 5, half-period length in clk_i cycles after reset (full period 2*DEFAULT_HALF).
PCNT_W, 16, width of the period counter.

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous, active-high reset (despite the name; 1 = reset)
start_i  input  1  pulse; start divided clock from IDLE
stop_i  input  1  pulse; request graceful stop
cfg_valid_i  input  1  new half-period value offered
cfg_half_i  input  CNT_W  requested half-period in clk_i cycles
cfg_ready_o  output  1  config slot free
cfg_applied_o  output  1  one-cycle pulse when pending ratio becomes active
clk_out_o  output  1  divided clock (registered)
rise_o  output  1  one-cycle pulse, first cycle clk_out_o reads 1
fall_o  output  1  one-cycle pulse, first cycle clk_out_o reads 0
busy_o  output  1  high in RUN or DRAIN
done_o  output  1  one-cycle pulse on DRAIN->IDLE
period_cnt_o  output  PCNT_W  count of rising edges since last start

Behaviour:
- Reset (async, rstn_i=1): state IDLE; counter 0; active half = DEFAULT_HALF; pending empty; clk_out_o, rise_o, fall_o, busy_o, done_o, cfg_applied_o = 0; cfg_ready_o = 1; period_cnt_o = 0. Reset asserted mid-RUN or mid-DRAIN forces clk_out_o low immediately (async).
- States: IDLE, RUN, DRAIN. busy_o = (state != IDLE).
- IDLE: clk_out_o held 0, counter held 0. start_i=1 -> RUN; counter 0; period_cnt_o cleared. stop_i is ignored in IDLE. start_i and stop_i high together in IDLE -> RUN.
- RUN and DRAIN counting: counter increments each cycle. When counter == half-1: counter -> 0 and clk_out_o toggles.
  - rise_o/fall_o are registered alongside the toggle.
  - period_cnt_o increments, wrapping, in the same edge that clk_out_o goes 0->1.
  - First rise occurs half cycles after the start-capture edge.
- stop_i in RUN -> DRAIN.
  - If clk_out_o is 0 on entry: go to IDLE on the next edge, counter cleared, done_o pulse.
  - Otherwise keep counting until the falling toggle; at that same edge go to IDLE, with fall_o and done_o pulsing together.
  - A high phase is never truncated. start_i and stop_i are ignored in DRAIN.
- Config handshake: cfg_ready_o = ~pending_valid. A transfer occurs when cfg_valid_i & cfg_ready_o.
  - cfg_half_i = 0 is clamped to 1 when captured.
  - Application point in IDLE: pending is applied on the cycle after capture.
  - Application point in RUN/DRAIN: pending is applied only at an edge where clk_out_o goes 1->0. The new half governs the next low phase.
  - On application: pending cleared, cfg_applied_o pulses for one cycle, cfg_ready_o returns 1 the following cycle.
  - A transfer cannot occur in the same cycle as application, because ready is low while pending.
- half = 1: clk_out_o toggles every cycle; rise_o and fall_o alternate.
- All outputs are registered. No combinational path from inputs to outputs except cfg_ready_o, which depends only on internal state.

Test Plan:
1. Reset, then start_i pulse at cycle 0 with default half 5 -> clk_out_o rises at edge 5, falls at edge 10, rises at edge 15. rise_o pulses at 5 and 15. period_cnt_o = 2 after edge 15.
2. In RUN with half 5, send cfg 3 while clk_out_o is high -> cfg_ready_o low until the next falling edge, where cfg_applied_o pulses. The following low and high phases are 3 cycles each.
3. Send stop_i 2 cycles after a rising edge (half 5) -> DRAIN. clk_out_o stays high 3 more cycles, then falls with fall_o and done_o in the same cycle. busy_o drops and the state is IDLE.
4. Send stop_i while clk_out_o is low -> IDLE on the next edge, done_o pulse, clk_out_o stays 0, no rise_o.
5. cfg_half_i = 0 in IDLE, then start -> half clamped to 1. clk_out_o toggles every cycle; rise_o and fall_o alternate.
6. Assert rstn_i mid-RUN while clk_out_o is high -> clk_out_o and busy_o are 0 immediately without a clock edge, and active half is back to 5. After release, start_i reproduces the timing of test 1.
